// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 registered multiplexer with fixed-priority or
// round-robin arbitration and a valid/ready handshake on every channel.
//
// Parameters
//   WIDTH     data bits per channel (>= 1)
//   NCH       number of input channels (>= 2)
// Ports
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   in_data   NCH*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel request
//   in_ready  per-channel accept (combinational, at most one bit high)
//   rr_en     0 = fixed priority (lowest index wins), 1 = round-robin
//   out_data  registered selected data
//   out_valid registered output beat valid
//   out_ready downstream accept
//   out_grant registered one-hot source channel of out_data, 0 when idle
module mux_arb_nto1 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 rr_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH-1:0]       out_grant
);

  localparam int unsigned PW = $clog2(NCH);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [NCH-1:0]   out_grant_q, out_grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    scan_idx;
  logic [NCH-1:0]   win_onehot;
  logic [WIDTH-1:0] sel_data;

  // Output register may accept a new beat when empty or draining this cycle
  assign load = !out_valid_q || out_ready;

  // Winner search: scan order starts at ptr in round-robin mode, at 0 otherwise
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (rr_en) begin
        scan_idx = PW'((32'(ptr_q) + k) % NCH);
      end else begin
        scan_idx = PW'(k);
      end
      if (!win_found && in_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_onehot = NCH'(1) << win_idx;

  // Data mux for the winning channel
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (PW'(k) == win_idx) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst_n so nothing is accepted while reset is held
  assign in_ready = (load && win_found && rst_n) ? win_onehot : '0;

  // Next-state for output register and round-robin pointer
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_grant_d = out_grant_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (win_found) begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
        out_grant_d = win_onehot;
        if (rr_en) begin
          ptr_d = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + PW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
        out_grant_d = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_grant_q <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_grant_q <= out_grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_grant = out_grant_q;

`ifndef SYNTHESIS
  // Protocol checks, sampled mid-cycle once inputs have settled
  a_grant_onehot0 : assert property (@(negedge clk) disable iff (!rst_n)
    $onehot0(out_grant));
  a_ready_onehot0 : assert property (@(negedge clk) disable iff (!rst_n)
    $onehot0(in_ready));
  a_ready_needs_valid : assert property (@(negedge clk) disable iff (!rst_n)
    (in_ready & ~in_valid) == '0);
  a_stall_stable : assert property (@(negedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_grant)));
  a_valid_has_grant : assert property (@(negedge clk) disable iff (!rst_n)
    out_valid |-> (out_grant != '0));

  for (genvar gi = 0; gi < NCH; gi++) begin : g_xfer_chk
    a_xfer_data : assert property (@(negedge clk) disable iff (!rst_n)
      (in_valid[gi] && in_ready[gi]) |=>
        (out_data == $past(in_data[gi*WIDTH +: WIDTH])));
  end
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Testbench for mux_arb_nto1 (WIDTH=8, NCH=4): directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_mux_arb_nto1;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        rr_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_grant;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_valid = 0;
  int m_data  = 0;
  int m_grant = 0;
  int m_ptr   = 0;

  mux_arb_nto1 #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grant (out_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First valid channel in the arbitration scan order, -1 if none
  function automatic int winner(input logic [3:0] v, input logic rr, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = rr ? (p + k) % 4 : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_grant", 32'(out_grant), m_valid != 0 ? 32'(1) << m_grant : 32'(0));
    chk("out_data",  32'(out_data),  32'(m_data));
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_grant = 0;
    m_ptr   = 0;
  endtask

  // One clock: check mid-cycle, then advance model on the rising edge
  task automatic cycle();
    int         w;
    logic       ld;
    logic [3:0] exp_rdy;
    ld      = (m_valid == 0) || out_ready;
    w       = winner(in_valid, rr_en, m_ptr);
    exp_rdy = (ld && w >= 0) ? 4'(1 << w) : 4'b0000;
    @(negedge clk);
    check_outputs();
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (ld) begin
      if (w >= 0) begin
        m_data  = 32'(in_data[w*8 +: 8]);
        m_valid = 1;
        m_grant = w;
        if (rr_en) m_ptr = (w + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    rr_en     = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_grant", 32'(out_grant), 32'(0));
    chk("rst_out_data",  32'(out_data),  32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) cycle();

    // Fixed priority: ch1 wins repeatedly, then ch2 once ch1 drops
    rr_en    = 1'b0;
    in_data  = 32'h3322_1100;
    in_valid = 4'b1110;
    repeat (3) cycle();
    chk("fixed_grant", 32'(out_grant), 32'(4'b0010));
    chk("fixed_data",  32'(out_data),  32'(8'h11));
    in_valid = 4'b1100;
    cycle();
    chk("fixed_drop_grant", 32'(out_grant), 32'(4'b0100));
    chk("fixed_drop_data",  32'(out_data),  32'(8'h22));

    // Round-robin from pointer 0 with all channels requesting
    rr_en    = 1'b1;
    in_data  = 32'hD3C2_B1A0;
    in_valid = 4'b1111;
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_grant", 32'(out_grant), 32'(rr_seq[i]));
    end

    // Backpressure: hold A5 from ch2 while ch0 waits
    rr_en    = 1'b0;
    in_data  = 32'h00A5_005A;
    in_valid = 4'b0100;
    cycle();
    chk("bp_load_data", 32'(out_data), 32'(8'hA5));
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_data",  32'(out_data),  32'(8'hA5));
      chk("bp_hold_grant", 32'(out_grant), 32'(4'b0100));
      chk("bp_in_ready",   32'(in_ready),  32'(0));
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_grant", 32'(out_grant), 32'(4'b0001));
    chk("bp_release_data",  32'(out_data),  32'(8'h5A));

    // Mode switch: ch2 grant in RR mode leaves ptr=3
    rr_en    = 1'b1;
    in_data  = 32'h4433_2211;
    in_valid = 4'b0100;
    cycle();
    rr_en    = 1'b0;
    in_valid = 4'b1001;
    cycle();
    chk("mode_fixed_grant", 32'(out_grant), 32'(4'b0001));
    rr_en = 1'b1;
    cycle();
    chk("mode_rr_grant", 32'(out_grant), 32'(4'b1000));
    chk("mode_rr_data",  32'(out_data),  32'(8'h44));

    // Drain: output empties, data holds
    in_valid = 4'b0000;
    cycle();
    chk("drain_valid", 32'(out_valid), 32'(0));
    chk("drain_grant", 32'(out_grant), 32'(0));
    chk("drain_data",  32'(out_data),  32'(8'h44));
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      rr_en     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset mid-stream with a beat held
    in_data   = 32'h0000_00C7;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    cycle();
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_grant", 32'(out_grant), 32'(0));
    chk("mid_rst_data",  32'(out_data),  32'(0));
    chk("mid_rst_ready", 32'(in_ready),  32'(0));
    @(posedge clk); #1;
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N-to-1 registered multiplexer with built-in arbitration and a valid/ready handshake on every channel. It is the successor to the team's fixed 4-input priority mux. It adds:
- generic width and channel count;
- runtime-selectable fixed-priority or round-robin arbitration;
- backpressure;
- an output grant vector.

It sits between several producers and one shared downstream consumer. It carries its own concurrent assertions.

## Interface
- `WIDTH`, default 4: data bits per channel, ≥1.
- `NCH`, default 4: number of input channels, ≥2. The pointer width is `PW = $clog2(NCH)`.
- `clk`: input, 1 bit. The single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_data`: input, `NCH*WIDTH` bits. Channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`: input, `NCH` bits. Per-channel request.
- `in_ready`: output, `NCH` bits. Per-channel accept. At most one bit is high at a time.
- `rr_en`: input, 1 bit. 0 selects fixed priority (lowest index wins). 1 selects round-robin.
- `out_data`: output, `WIDTH` bits. Registered selected data.
- `out_valid`: output, 1 bit. Registered; `out_data` holds a beat.
- `out_ready`: input, 1 bit. Downstream accept.
- `out_grant`: output, `NCH` bits. Registered one-hot index of the channel that supplied `out_data`. It is 0 when `out_valid` is 0.

## Operation
- Internal signal `load = !out_valid || out_ready`. The output register may take a new beat when `load` is 1.
- **Winner selection** (combinational, from `in_valid`):
  - Fixed mode: the lowest index i with `in_valid[i]` = 1.
  - Round-robin mode: the first valid index found scanning `ptr`, `ptr+1`, … `NCH-1`, 0, … `ptr-1`.
- **`in_ready`:** `in_ready[w]` = 1 only when `load` = 1, a winner w exists, and `rst_n` = 1. All other bits are 0. `in_ready` is never high for a channel with `in_valid` = 0.
- **Transfer** on a rising edge with `in_valid[w] && in_ready[w]`:
  - `out_data` ← channel w data.
  - `out_valid` ← 1.
  - `out_grant` ← one-hot(w).
- **`load` = 1 with no valid input:**
  - `out_valid` ← 0.
  - `out_grant` ← 0.
  - `out_data` holds its last value.
- **`load` = 0 (stall):** `out_data`, `out_valid` and `out_grant` hold.
- **Pointer `ptr` (PW bits):**
  - Updates only on a transfer while `rr_en` = 1: `ptr` ← (w+1) mod `NCH`. The wrap from `NCH-1` goes to 0.
  - In fixed mode `ptr` holds.
- **`rr_en` changes:** sampled combinationally each cycle. A change affects the next selection only; no in-flight beat is altered.
- **Assertions** are disabled while `rst_n` = 0 and sampled on the falling edge of `clk`:
  - `out_grant` is onehot0.
  - `in_ready` is onehot0.
  - `in_ready[i]` implies `in_valid[i]`.
  - `out_valid && !out_ready` implies `out_data` and `out_grant` are stable in the next cycle.
  - `out_valid` implies `out_grant != 0`.
  - A transfer from channel i implies, one cycle later, `out_data == $past(in_data[i])`.

## Timing
- **Reset:**
  - `rst_n` low immediately forces `out_valid`=0, `out_data`=0, `out_grant`=0, `ptr`=0.
  - `in_ready` is forced to 0 combinationally.
  - Reset mid-transfer discards the held beat without completion.
- **Latency:** one cycle from input accept to `out_valid`.
- **Throughput:** one beat per cycle while `out_ready` = 1.
- **Output registers:** `out_data`, `out_valid` and `out_grant` are registered.
- **Combinational paths:**
  - `in_ready` depends on `in_valid`, `rr_en`, `ptr`, `out_valid` and `out_ready`.
  - Upstream must not make `in_valid` depend on `in_ready`.
- **Back-to-back:** when `out_valid` and `out_ready` are both 1 and an input is valid in the same cycle, the held beat retires and the new beat loads on the same edge, with no bubble.
- **Input hold rule:** once asserted, an upstream `in_valid` with its data is held until accepted. The block does not check this; channels losing arbitration simply wait.

## Test plan
All scenarios use WIDTH=8, NCH=4.
- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 -> `out_valid`, `out_grant`, `out_data` and `in_ready` are all 0 immediately. After release with no requests they stay 0.
- **Fixed priority:** `rr_en`=0, `in_valid`=4'b1110, data ch1=8'h11, ch2=8'h22, ch3=8'h33, `out_ready`=1, inputs held each cycle -> grants ch1 on three consecutive cycles (`out_grant`=4'b0010, `out_data`=8'h11). Dropping ch1 then gives ch2.
- **Round-robin:** `rr_en`=1, all four channels valid continuously, `out_ready`=1 -> `out_grant` sequence 0001, 0010, 0100, 1000, 0001 (pointer wraps from 3 to 0).
- **Backpressure:** `out_valid`=1 with 8'hA5 from ch2, `out_ready`=0 for 3 cycles while ch0 is valid -> `out_data`/`out_grant` stay 8'hA5/0100 and `in_ready`=0. On `out_ready`=1, ch0 loads next edge with no idle cycle.
- **Mode switch:** `rr_en`=1, after a ch2 grant (`ptr`=3) switch to `rr_en`=0 with ch0 and ch3 valid -> ch0 granted and `ptr` holds 3. Switching back with ch0 and ch3 valid grants ch3.
- **Drain:** all `in_valid`=0 with `out_ready`=1 -> `out_valid` and `out_grant` drop to 0 next cycle, `out_data` holds its last value, and no assertion fires.
